// File: rtl/tl_ul_sram_responder.sv
// tl_ul_sram_responder
//   TileLink-UL manager endpoint backed by a word-addressed 32-bit SRAM.
//   Single-beat requests, one response register, one request per cycle
//   sustained when the D channel is always ready.
//
// Ports
//   clock, reset_n        : posedge clock, synchronous active-low reset
//   a_valid / a_ready     : A-channel handshake (a_ready is combinational)
//   a_opcode .. a_corrupt : A-channel request fields (a_param ignored)
//   d_valid / d_ready     : D-channel handshake
//   d_opcode .. d_corrupt : D-channel response fields, held until d_ready
//   err_count             : saturating count of denied responses accepted on D
module tl_ul_sram_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0800_0000,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned SRC_W      = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [2:0]       a_opcode,
    input  logic [2:0]       a_param,
    input  logic [1:0]       a_size,
    input  logic [SRC_W-1:0] a_source,
    input  logic [31:0]      a_address,
    input  logic [3:0]       a_mask,
    input  logic [31:0]      a_data,
    input  logic             a_corrupt,
    output logic             d_valid,
    input  logic             d_ready,
    output logic [2:0]       d_opcode,
    output logic [1:0]       d_param,
    output logic [1:0]       d_size,
    output logic [SRC_W-1:0] d_source,
    output logic             d_sink,
    output logic             d_denied,
    output logic [31:0]      d_data,
    output logic             d_corrupt,
    output logic [7:0]       err_count
);

    localparam int unsigned TAG_LSB = DEPTH_LOG2 + 2;

    typedef enum logic [2:0] {
        PUT_FULL    = 3'd0,
        PUT_PARTIAL = 3'd1,
        ARITH       = 3'd2,
        LOGICAL     = 3'd3,
        GET         = 3'd4,
        INTENT      = 3'd5
    } a_op_e;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1,
        HINT_ACK        = 3'd2
    } d_op_e;

    logic [31:0]           mem [0:(1 << DEPTH_LOG2) - 1];
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  in_range;
    logic                  aligned;
    logic [3:0]            full_mask;
    logic                  op_ok;
    logic                  mask_ok;
    logic                  denied;
    logic                  is_put;
    d_op_e                 resp_op;
    logic                  a_fire;
    logic                  d_fire;
    logic                  do_write;
    logic                  unused_a_param;

    assign unused_a_param = ^a_param;

    assign word_idx = a_address[DEPTH_LOG2+1:2];
    assign in_range = (a_address[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);

    // Alignment and the lane mask a PutFull must carry for its size/offset.
    always_comb begin
        aligned   = 1'b0;
        full_mask = 4'hF;
        case (a_size)
            2'd0: begin
                aligned   = 1'b1;
                full_mask = 4'b0001 << a_address[1:0];
            end
            2'd1: begin
                aligned   = ~a_address[0];
                full_mask = 4'b0011 << a_address[1:0];
            end
            2'd2: begin
                aligned   = (a_address[1:0] == 2'b00);
                full_mask = 4'hF;
            end
            default: begin
                aligned   = 1'b0;
                full_mask = 4'hF;
            end
        endcase
    end

    assign is_put  = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);
    assign op_ok   = is_put || (a_opcode == GET);
    assign mask_ok = (a_opcode != PUT_FULL) || (a_mask == full_mask);
    assign denied  = ~(in_range & (a_size != 2'd3) & aligned & mask_ok & op_ok);

    always_comb begin
        resp_op = ACCESS_ACK;
        case (a_opcode)
            GET, ARITH, LOGICAL: resp_op = ACCESS_ACK_DATA;
            INTENT:              resp_op = HINT_ACK;
            default:             resp_op = ACCESS_ACK;
        endcase
    end

    assign a_ready  = reset_n & (~d_valid | d_ready);
    assign a_fire   = a_valid & a_ready;
    assign d_fire   = d_valid & d_ready;
    // Poisoned write data is dropped silently; the response is still a plain ack.
    assign do_write = a_fire & is_put & ~denied & ~a_corrupt;

    assign d_param = '0;
    assign d_sink  = 1'b0;

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (do_write) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (a_mask[i]) begin
                    mem[word_idx][8*i +: 8] <= a_data[8*i +: 8];
                end
            end
        end
    end

    // Response register: a new fire overwrites it even while the old one is
    // being consumed, which is what gives one response per cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            d_valid   <= 1'b0;
            d_opcode  <= '0;
            d_size    <= '0;
            d_source  <= '0;
            d_denied  <= 1'b0;
            d_data    <= '0;
            d_corrupt <= 1'b0;
            err_count <= '0;
        end else begin
            if (d_fire && d_denied && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (a_fire) begin
                d_valid   <= 1'b1;
                d_opcode  <= resp_op;
                d_size    <= a_size;
                d_source  <= a_source;
                d_denied  <= denied;
                d_corrupt <= denied & (resp_op == ACCESS_ACK_DATA);
                d_data    <= (!denied && (resp_op == ACCESS_ACK_DATA)) ? mem[word_idx] : '0;
            end else if (d_fire) begin
                d_valid <= 1'b0;
            end
        end
    end

endmodule
